// File: rtl/axis_small_fifo.sv
// Small AXI-Stream FIFO: circular buffer with a registered occupancy count.
// Define AXIS_SMALL_FIFO_PACKET_MODE_EN to hold output until a whole packet (or a full FIFO) is stored.
module axis_small_fifo #(
    parameter int BUS_WIDTH  = 1,
    parameter int USER_WIDTH = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          aclk,
    input  logic                          arst,
    input  logic [BUS_WIDTH*8-1:0]        s_axis_tdata,
    input  logic [BUS_WIDTH-1:0]          s_axis_tkeep,
    input  logic [USER_WIDTH-1:0]         s_axis_tuser,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [BUS_WIDTH*8-1:0]        m_axis_tdata,
    output logic [BUS_WIDTH-1:0]          m_axis_tkeep,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   data_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = BUS_WIDTH * 8;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [DW-1:0]         data;
        logic [BUS_WIDTH-1:0]  keep;
        logic [USER_WIDTH-1:0] user;
        logic                  last;
    } beat_t;

    beat_t         mem_q [FIFO_DEPTH];
    beat_t         wr_beat;
    beat_t         head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_en, rd_en;

    assign wr_beat = '{data: s_axis_tdata, keep: s_axis_tkeep, user: s_axis_tuser, last: s_axis_tlast};
    assign head    = mem_q[rd_ptr_q];

    // Full blocks input outright; nothing passes through a full FIFO.
    assign s_axis_tready = count_q < FULL_CNT;
    assign wr_en         = s_axis_tvalid & s_axis_tready;
    assign rd_en         = m_axis_tvalid & m_axis_tready;

    assign m_axis_tdata = head.data;
    assign m_axis_tkeep = head.keep;
    assign m_axis_tuser = head.user;
    assign m_axis_tlast = head.last;
    assign data_count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge aclk) begin
        if (wr_en && !arst) mem_q[wr_ptr_q] <= wr_beat;
    end

`ifdef AXIS_SMALL_FIFO_PACKET_MODE_EN
    logic [AW:0] pkt_q, pkt_d;

    always_comb begin
        pkt_d = pkt_q;
        case ({wr_en & s_axis_tlast, rd_en & head.last})
            2'b10:   pkt_d = pkt_q + 1'b1;
            2'b01:   pkt_d = pkt_q - 1'b1;
            default: pkt_d = pkt_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) pkt_q <= '0;
        else      pkt_q <= pkt_d;
    end

    // A full FIFO releases regardless, so packets longer than the FIFO cannot deadlock.
    assign m_axis_tvalid = (count_q != '0) && ((pkt_q != '0) || (count_q == FULL_CNT));
`else
    assign m_axis_tvalid = count_q != '0;
`endif
endmodule

// File: doc/axis_small_fifo.md
AXIS_SMALL_FIFO -- requirements
Module: axis_small_fifo

Interface
REQ-001 Parameter BUS_WIDTH, default 1: tdata width in bytes; legal values are 1 to 64.
REQ-002 Parameter USER_WIDTH, default 1: tuser width in bits; legal values are 1 to 32.
REQ-003 Parameter FIFO_DEPTH, default 4: number of storage entries; legal values are powers of 2 from 2 to 64.
REQ-004 aclk  in  1  single clock; all logic is on the rising edge.
REQ-005 arst  in  1  reset; synchronous, active-high.
REQ-006 s_axis_tdata  in  BUS_WIDTH*8  input data.
REQ-007 s_axis_tkeep  in  BUS_WIDTH  input byte qualifiers; stored as-is.
REQ-008 s_axis_tuser  in  USER_WIDTH  input sideband; stored as-is.
REQ-009 s_axis_tlast  in  1  input end-of-packet marker.
REQ-010 s_axis_tvalid  in  1  input beat valid.
REQ-011 s_axis_tready  out  1  FIFO can accept a beat.
REQ-012 m_axis_tdata/tkeep/tuser/tlast  out  as for s_axis  head-entry fields.
REQ-013 m_axis_tvalid  out  1  head entry is presentable.
REQ-014 m_axis_tready  in  1  downstream accepts a beat.
REQ-015 data_count  out  clog2(FIFO_DEPTH)+1  number of occupied entries.

Function
REQ-016 A write SHALL occur on an edge where s_axis_tvalid & s_axis_tready; a read SHALL occur on an edge where m_axis_tvalid & m_axis_tready.
REQ-017 Storage SHALL be a circular buffer with write and read pointers of clog2(FIFO_DEPTH) bits, each incremented modulo FIFO_DEPTH on a write or read respectively.
REQ-018 s_axis_tready SHALL be the combinational result data_count < FIFO_DEPTH; there is no pass-through when the FIFO is full.
REQ-019 The m_axis_* fields SHALL always reflect the entry at the read pointer; their values while m_axis_tvalid=0 are don't-care.
REQ-020 Latency: a beat written at edge N SHALL be presentable (m_axis_tvalid=1) in cycle N+1 when the FIFO was empty.
REQ-021 data_count is registered: +1 on a write only, -1 on a read only, unchanged on a simultaneous read and write.
REQ-022 A simultaneous read and write when full SHALL be impossible, because s_axis_tready=0 when full.
REQ-023 A simultaneous read and write when data_count=1 SHALL present the new beat in the next cycle with no bubble.
REQ-024 Beats SHALL leave in arrival order with all fields unaltered.
REQ-025 Without packet mode, m_axis_tvalid SHALL be data_count != 0.
REQ-026 m_axis_tvalid SHALL NOT depend combinationally on m_axis_tready, and s_axis_tready SHALL NOT depend combinationally on s_axis_tvalid.

Reset
REQ-027 While arst=1 at an edge, the pointers, data_count and the packet counter SHALL clear to 0.
REQ-028 Consequently m_axis_tvalid=0 and s_axis_tready=1 in the cycle after that edge.
REQ-029 Storage contents SHALL NOT be reset.
REQ-030 A reset mid-operation SHALL discard all stored beats, including partial packets.
REQ-031 No write or read SHALL be counted on an edge where arst=1.

Configuration
REQ-032 Macro AXIS_SMALL_FIFO_PACKET_MODE_EN SHALL select packet mode.
REQ-033 When the macro is defined, a packet counter of clog2(FIFO_DEPTH)+1 bits SHALL track complete stored packets:
- +1 on a write with tlast=1
- -1 on a read with tlast=1
- unchanged when both occur on the same edge.
REQ-034 When the macro is defined, m_axis_tvalid SHALL be (data_count != 0) & ((packet count != 0) | (data_count == FIFO_DEPTH)); the full-FIFO release prevents deadlock on packets longer than FIFO_DEPTH.
REQ-035 When the macro is undefined, the packet counter SHALL be absent and REQ-025 SHALL apply.

Verification
REQ-036 After reset, write 4 beats 0x00..0x03 with m_axis_tready=0 (FIFO_DEPTH=4): s_axis_tready=0 after the 4th beat, data_count=4, m_axis_tdata=0x00.
REQ-037 From full, assert m_axis_tready for 4 cycles: read 0x00,0x01,0x02,0x03 in order; data_count reaches 0 and m_axis_tvalid drops.
REQ-038 Continuous write and read with both sides always valid/ready: one beat per cycle, data_count stays 1, no bubbles, first output in cycle N+1.
REQ-039 Random m_axis_tready (50%) and s_axis_tvalid toggled every 2 cycles, counting data 0..255: output sequence is exactly 0..255 with no loss or duplication.
REQ-040 Packet mode: write 3 beats with tlast=0 and FIFO_DEPTH=4 -> m_axis_tvalid stays 0; on the 4th beat with tlast=1, m_axis_tvalid=1 next cycle; an unterminated 4-beat fill also releases.
REQ-041 Assert arst for one edge with data_count=3: data_count=0, m_axis_tvalid=0 and s_axis_tready=1 next cycle; a subsequent beat 0xA5 is output first.
